// File: rtl/layer_compositor.sv
// layer_compositor: composites N_LAYERS positioned sprite layers over the
// camera background. Lower layer index wins. Each layer has a rectangular or
// circular mask, and its pixels are transparent unless A8[7] is set.
// Layer geometry is held in a shadow copy and committed at frame start.
// The block also reports, once per frame, which layers had opaque pixels
// overlapping another opaque layer.
//
// Ports
//   i_clk, i_rst          pixel clock, async active-high reset
//   i_h_count, i_v_count  signed raster counters, (0,0) = frame start
//   i_red/green/blue      background pixel aligned with the counters
//   o_layer_en            per-layer window hit (combinational), to fetchers
//   i_layer_q             fetcher data {R8,G8,B8,A8} per layer, 1 cycle after hit
//   i_cfg_*               layer configuration write (valid/ready)
//   o_cfg_ready           low only in the frame-start cycle
//   o_red/green/blue      composited pixel, 2 cycles after the counters
//   o_sel_valid/layer     winning layer of the output pixel
//   o_overlap             per-layer overlap flags of the previous frame
//   o_frame_done          pulse alongside each o_overlap update
module layer_compositor #(
   parameter int N_LAYERS = 4,
   parameter int COLOR_W  = 10,
   parameter int COORD_W  = 13,
   parameter int X_START  = 216,
   parameter int Y_START  = 27,
   parameter int H_ACT    = 800,
   parameter int V_ACT    = 600,
   localparam int LAYER_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic signed [COORD_W-1:0] i_h_count,
   input  logic signed [COORD_W-1:0] i_v_count,
   input  logic [COLOR_W-1:0]        i_red,
   input  logic [COLOR_W-1:0]        i_green,
   input  logic [COLOR_W-1:0]        i_blue,
   output logic [N_LAYERS-1:0]       o_layer_en,
   input  logic [32*N_LAYERS-1:0]    i_layer_q,
   input  logic                      i_cfg_valid,
   output logic                      o_cfg_ready,
   input  logic [LAYER_W-1:0]        i_cfg_layer,
   input  logic signed [COORD_W-1:0] i_cfg_x,
   input  logic signed [COORD_W-1:0] i_cfg_y,
   input  logic [9:0]                i_cfg_w,
   input  logic [9:0]                i_cfg_h,
   input  logic                      i_cfg_en,
   input  logic                      i_cfg_circle,
   output logic [COLOR_W-1:0]        o_red,
   output logic [COLOR_W-1:0]        o_green,
   output logic [COLOR_W-1:0]        o_blue,
   output logic                      o_sel_valid,
   output logic [LAYER_W-1:0]        o_sel_layer,
   output logic [N_LAYERS-1:0]       o_overlap,
   output logic                      o_frame_done
);

   // Coordinate math is done two bits wider than the counters so that
   // position + size never wraps.
   localparam int EW = COORD_W + 2;
   localparam logic signed [EW-1:0] H_ACT_E = EW'(H_ACT);
   localparam logic signed [EW-1:0] V_ACT_E = EW'(V_ACT);
   localparam int PAD  = (COLOR_W > 8) ? COLOR_W - 8 : 0;
   localparam int DROP = (COLOR_W < 8) ? 8 - COLOR_W : 0;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [9:0]         w;
      logic [9:0]         h;
      logic               en;
      logic               circle;
   } layer_cfg_t;

   // 8-bit fetcher channel, left-justified into COLOR_W.
   function automatic logic [COLOR_W-1:0] expand8(input logic [7:0] v);
      return COLOR_W'(((COLOR_W + 8)'(v) << PAD) >> DROP);
   endfunction

   layer_cfg_t          shadow_cfg [N_LAYERS];
   layer_cfg_t          active_cfg [N_LAYERS];
   layer_cfg_t          eff_cfg    [N_LAYERS];
   layer_cfg_t          cfg_wr;
   logic [N_LAYERS-1:0] pending;
   logic                refresh;
   logic                cfg_fire;

   assign refresh     = (i_h_count == '0) && (i_v_count == '0);
   assign o_cfg_ready = !refresh;
   assign cfg_fire    = i_cfg_valid && o_cfg_ready;
   assign cfg_wr      = {i_cfg_x, i_cfg_y, i_cfg_w, i_cfg_h, i_cfg_en, i_cfg_circle};

   // Shadow/active register file. Writes never land in the refresh cycle
   // (ready is low), so commit and write cannot collide. Layer indices with
   // no matching entry decode to nothing and the write is dropped.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pending <= '0;
         for (int k = 0; k < N_LAYERS; k++) begin
            shadow_cfg[k] <= '0;
            active_cfg[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_LAYERS; k++) begin
            if (refresh && pending[k]) begin
               active_cfg[k] <= shadow_cfg[k];
               pending[k]    <= 1'b0;
            end else if (cfg_fire && (i_cfg_layer == LAYER_W'(k))) begin
               shadow_cfg[k] <= cfg_wr;
               pending[k]    <= 1'b1;
            end
         end
      end
   end

   // Stage 0: window hit per layer.
   logic signed [COORD_W-1:0] ax, ay;
   logic signed [EW-1:0]      ax_e, ay_e;
   logic                      in_act;
   logic [N_LAYERS-1:0]       hit;
   logic [31:0]               q_arr [N_LAYERS];
   logic [N_LAYERS-1:0]       opaque;
   logic [7*N_LAYERS-1:0]     unused_q_alpha;

   assign ax     = i_h_count - COORD_W'(X_START);
   assign ay     = i_v_count - COORD_W'(Y_START);
   assign ax_e   = EW'(ax);
   assign ay_e   = EW'(ay);
   assign in_act = !ax_e[EW-1] && !ay_e[EW-1] && (ax_e < H_ACT_E) && (ay_e < V_ACT_E);

   for (genvar k = 0; k < N_LAYERS; k++) begin : g_layer
      logic signed [EW-1:0] x_e, y_e, w_e, h_e, half_e;
      logic [9:0]           half;
      logic signed [10:0]   dx, dy;
      logic [21:0]          dx_sq, dy_sq, r_sq;
      logic                 in_rect, in_circle;

      // The refresh pixel itself already sees the configuration being committed.
      assign eff_cfg[k] = (refresh && pending[k]) ? shadow_cfg[k] : active_cfg[k];

      assign x_e    = EW'($signed(eff_cfg[k].x));
      assign y_e    = EW'($signed(eff_cfg[k].y));
      assign w_e    = $signed(EW'(eff_cfg[k].w));
      assign h_e    = $signed(EW'(eff_cfg[k].h));
      assign half   = {1'b0, eff_cfg[k].w[9:1]};
      assign half_e = $signed(EW'(half));

      assign in_rect = (ax_e >= x_e) && (ax_e < x_e + w_e) &&
                       (ay_e >= y_e) && (ay_e < y_e + h_e);

      // Circle centre and radius both derive from w; h only bounds the rect.
      assign dx        = 11'(ax_e - (x_e + half_e));
      assign dy        = 11'(ay_e - (y_e + half_e));
      assign dx_sq     = 22'(dx) * 22'(dx);
      assign dy_sq     = 22'(dy) * 22'(dy);
      assign r_sq      = 22'(half) * 22'(half);
      assign in_circle = (dx_sq + dy_sq) <= r_sq;

      assign hit[k] = eff_cfg[k].en && in_act && in_rect &&
                      (!eff_cfg[k].circle || in_circle);

      assign q_arr[k]                 = i_layer_q[32*k +: 32];
      assign opaque[k]                = q_arr[k][7];
      assign unused_q_alpha[7*k +: 7] = q_arr[k][6:0];
   end

   assign o_layer_en = hit;

   // Stage 1: registered hits meet fetcher data.
   logic [N_LAYERS-1:0] hit_r;
   logic [COLOR_W-1:0]  bg_red_r, bg_green_r, bg_blue_r;
   logic [N_LAYERS-1:0] visible;
   logic                win_valid;
   logic [LAYER_W-1:0]  win_layer;
   logic [31:0]         win_q;
   logic                multi;
   logic [N_LAYERS-1:0] overlap_acc;

   assign visible = hit_r & opaque;
   assign multi   = |(visible & (visible - N_LAYERS'(1)));

   always_comb begin
      win_valid = 1'b0;
      win_layer = '0;
      for (int k = N_LAYERS - 1; k >= 0; k--) begin
         if (visible[k]) begin
            win_valid = 1'b1;
            win_layer = LAYER_W'(k);
         end
      end
   end

   assign win_q = q_arr[win_layer];

   // Stage 2 plus per-frame overlap capture.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         hit_r        <= '0;
         bg_red_r     <= '0;
         bg_green_r   <= '0;
         bg_blue_r    <= '0;
         o_red        <= '0;
         o_green      <= '0;
         o_blue       <= '0;
         o_sel_valid  <= 1'b0;
         o_sel_layer  <= '0;
         overlap_acc  <= '0;
         o_overlap    <= '0;
         o_frame_done <= 1'b0;
      end else begin
         hit_r       <= hit;
         bg_red_r    <= i_red;
         bg_green_r  <= i_green;
         bg_blue_r   <= i_blue;
         o_sel_valid <= win_valid;
         o_sel_layer <= win_layer;
         if (win_valid) begin
            o_red   <= expand8(win_q[31:24]);
            o_green <= expand8(win_q[23:16]);
            o_blue  <= expand8(win_q[15:8]);
         end else begin
            o_red   <= bg_red_r;
            o_green <= bg_green_r;
            o_blue  <= bg_blue_r;
         end
         o_frame_done <= refresh;
         // A pixel in stage 1 during refresh belongs to the new frame.
         if (refresh) begin
            o_overlap   <= overlap_acc;
            overlap_acc <= multi ? visible : '0;
         end else if (multi) begin
            overlap_acc <= overlap_acc | visible;
         end
      end
   end

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;
   localparam int XS = 216;
   localparam int YS = 27;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [12:0] h_count, v_count;
   logic [9:0]         red, green, blue;
   logic [3:0]         layer_en;
   logic [127:0]       layer_q;
   logic               cfg_valid, cfg_ready;
   logic [1:0]         cfg_layer;
   logic signed [12:0] cfg_x, cfg_y;
   logic [9:0]         cfg_w, cfg_h;
   logic               cfg_en, cfg_circle;
   logic [9:0]         o_red, o_green, o_blue;
   logic               sel_valid;
   logic [1:0]         sel_layer;
   logic [3:0]         overlap;
   logic               frame_done;

   int checks = 0;
   int errors = 0;

   layer_compositor dut (
      .i_clk(clk), .i_rst(rst),
      .i_h_count(h_count), .i_v_count(v_count),
      .i_red(red), .i_green(green), .i_blue(blue),
      .o_layer_en(layer_en), .i_layer_q(layer_q),
      .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
      .i_cfg_layer(cfg_layer), .i_cfg_x(cfg_x), .i_cfg_y(cfg_y),
      .i_cfg_w(cfg_w), .i_cfg_h(cfg_h), .i_cfg_en(cfg_en), .i_cfg_circle(cfg_circle),
      .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
      .o_sel_valid(sel_valid), .o_sel_layer(sel_layer),
      .o_overlap(overlap), .o_frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input int ax, input int ay);
      h_count = 13'(ax + XS);
      v_count = 13'(ay + YS);
      #1;
   endtask

   task automatic set_blank();
      set_pix(-100, -10);
   endtask

   // Flush the pipeline, then present the frame-start pixel for one cycle.
   task automatic do_refresh();
      set_blank();
      tick();
      tick();
      h_count = '0;
      v_count = '0;
      tick();
      set_blank();
   endtask

   task automatic cfg_write(input int layer, input int x, input int y, input int w,
                            input int h, input logic en, input logic circ);
      int n;
      cfg_valid  = 1'b1;
      cfg_layer  = 2'(layer);
      cfg_x      = 13'(x);
      cfg_y      = 13'(y);
      cfg_w      = 10'(w);
      cfg_h      = 10'(h);
      cfg_en     = en;
      cfg_circle = circ;
      #1;
      n = 0;
      while (!cfg_ready && n < 8) begin
         tick();
         n++;
      end
      if (!cfg_ready) begin
         checks++;
         errors++;
         $display("FAIL cfg_ready_timeout layer %0d ready %b want 1", layer, cfg_ready);
      end
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cfg_valid = 1'b0; cfg_layer = '0; cfg_x = '0; cfg_y = '0;
      cfg_w = '0; cfg_h = '0; cfg_en = 1'b0; cfg_circle = 1'b0;
      layer_q = '0;
      red = 10'h155; green = 10'h155; blue = 10'h155;
      set_pix(5, 5);
      tick();
      tick();
      checks++;
      if ({o_red, o_green, o_blue, sel_valid} !== 31'h0) begin
         errors++;
         $display("FAIL reset_outputs got %h %h %h sel %b want 0", o_red, o_green, o_blue, sel_valid);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (layer_en !== 4'b0000) begin
         errors++;
         $display("FAIL reset_layer_en got %b want 0000", layer_en);
      end
      tick();
      tick();
      checks++;
      if ({o_red, o_green, o_blue} !== {10'h155, 10'h155, 10'h155}) begin
         errors++;
         $display("FAIL reset_bg got %h %h %h want 155 155 155", o_red, o_green, o_blue);
      end
      checks++;
      if ({sel_valid, overlap, frame_done} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got sel %b ovl %b fd %b want 0", sel_valid, overlap, frame_done);
      end
   endtask

   task automatic test_priority();
      layer_q[31:0]  = 32'hFF00_0080;
      layer_q[63:32] = 32'h0000_FF80;
      cfg_write(0, 10, 10, 20, 20, 1'b1, 1'b0);
      cfg_write(1, 15, 15, 20, 20, 1'b1, 1'b0);
      do_refresh();
      set_pix(16, 16);
      checks++;
      if (layer_en !== 4'b0011) begin
         errors++;
         $display("FAIL prio_layer_en got %b want 0011", layer_en);
      end
      tick();
      tick();
      checks++;
      if ({o_red, o_green, o_blue} !== {10'h3FC, 10'h000, 10'h000}) begin
         errors++;
         $display("FAIL prio_rgb got %h %h %h want 3fc 000 000", o_red, o_green, o_blue);
      end
      checks++;
      if ({sel_valid, sel_layer} !== 3'b1_00) begin
         errors++;
         $display("FAIL prio_sel got %b %0d want 1 0", sel_valid, sel_layer);
      end
      do_refresh();
      checks++;
      if (overlap !== 4'b0011 || frame_done !== 1'b1) begin
         errors++;
         $display("FAIL prio_overlap got %b fd %b want 0011 fd 1", overlap, frame_done);
      end
      tick();
      checks++;
      if (frame_done !== 1'b0) begin
         errors++;
         $display("FAIL prio_frame_done_pulse got %b want 0", frame_done);
      end
   endtask

   task automatic test_transparency();
      layer_q[31:0] = 32'hFF00_0000;
      set_pix(16, 16);
      checks++;
      if (layer_en !== 4'b0011) begin
         errors++;
         $display("FAIL trans_layer_en got %b want 0011", layer_en);
      end
      tick();
      tick();
      checks++;
      if ({o_red, o_green, o_blue} !== {10'h000, 10'h000, 10'h3FC}) begin
         errors++;
         $display("FAIL trans_rgb got %h %h %h want 000 000 3fc", o_red, o_green, o_blue);
      end
      checks++;
      if ({sel_valid, sel_layer} !== 3'b1_01) begin
         errors++;
         $display("FAIL trans_sel got %b %0d want 1 1", sel_valid, sel_layer);
      end
      do_refresh();
      checks++;
      if (overlap !== 4'b0000) begin
         errors++;
         $display("FAIL trans_overlap got %b want 0000", overlap);
      end
   endtask

   task automatic test_circle();
      layer_q[95:64] = 32'h00FF_0080;
      cfg_write(2, 100, 100, 40, 40, 1'b1, 1'b1);
      do_refresh();
      set_pix(120, 100);
      checks++;
      if (layer_en !== 4'b0100) begin
         errors++;
         $display("FAIL circle_top_en got %b want 0100", layer_en);
      end
      tick();
      tick();
      checks++;
      if ({o_red, o_green, o_blue, sel_valid, sel_layer} !== {10'h000, 10'h3FC, 10'h000, 3'b1_10}) begin
         errors++;
         $display("FAIL circle_top_out got %h %h %h sel %b %0d want 000 3fc 000 sel 1 2",
                  o_red, o_green, o_blue, sel_valid, sel_layer);
      end
      set_pix(139, 120);
      checks++;
      if (layer_en !== 4'b0100) begin
         errors++;
         $display("FAIL circle_right_en got %b want 0100", layer_en);
      end
      set_pix(100, 100);
      checks++;
      if (layer_en !== 4'b0000) begin
         errors++;
         $display("FAIL circle_corner_en got %b want 0000", layer_en);
      end
      tick();
      tick();
      checks++;
      if ({o_red, o_green, o_blue, sel_valid} !== {10'h155, 10'h155, 10'h155, 1'b0}) begin
         errors++;
         $display("FAIL circle_corner_out got %h %h %h sel %b want 155 155 155 sel 0",
                  o_red, o_green, o_blue, sel_valid);
      end
   endtask

   task automatic test_double_buffer();
      layer_q[31:0] = 32'hFF00_0080;
      cfg_write(0, 50, 10, 20, 20, 1'b1, 1'b0);
      set_pix(16, 16);
      checks++;
      if (layer_en !== 4'b0011) begin
         errors++;
         $display("FAIL dbuf_old_pos got %b want 0011", layer_en);
      end
      set_pix(55, 16);
      checks++;
      if (layer_en !== 4'b0000) begin
         errors++;
         $display("FAIL dbuf_new_pos_early got %b want 0000", layer_en);
      end
      do_refresh();
      set_pix(55, 16);
      checks++;
      if (layer_en !== 4'b0001) begin
         errors++;
         $display("FAIL dbuf_new_pos got %b want 0001", layer_en);
      end
      set_pix(16, 16);
      checks++;
      if (layer_en !== 4'b0010) begin
         errors++;
         $display("FAIL dbuf_old_pos_gone got %b want 0010", layer_en);
      end
   endtask

   task automatic test_handshake_and_clip();
      layer_q[127:96] = 32'h1234_5680;
      h_count = '0;
      v_count = '0;
      cfg_valid = 1'b1; cfg_layer = 2'd3; cfg_x = -13'sd5; cfg_y = 13'sd0;
      cfg_w = 10'd10; cfg_h = 10'd10; cfg_en = 1'b1; cfg_circle = 1'b0;
      #1;
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL hs_ready_refresh got %b want 0", cfg_ready);
      end
      tick();
      set_blank();
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL hs_ready_after got %b want 1", cfg_ready);
      end
      tick();
      cfg_valid = 1'b0;
      set_pix(2, 2);
      checks++;
      if (layer_en !== 4'b0000) begin
         errors++;
         $display("FAIL hs_not_committed got %b want 0000", layer_en);
      end
      do_refresh();
      set_pix(0, 2);
      checks++;
      if (layer_en !== 4'b1000) begin
         errors++;
         $display("FAIL clip_ax0 got %b want 1000", layer_en);
      end
      set_pix(4, 2);
      checks++;
      if (layer_en !== 4'b1000) begin
         errors++;
         $display("FAIL clip_ax4 got %b want 1000", layer_en);
      end
      set_pix(5, 2);
      checks++;
      if (layer_en !== 4'b0000) begin
         errors++;
         $display("FAIL clip_ax5 got %b want 0000", layer_en);
      end
      set_pix(-1, 2);
      checks++;
      if (layer_en !== 4'b0000) begin
         errors++;
         $display("FAIL clip_ax_neg1 got %b want 0000", layer_en);
      end
      set_pix(-3, 2);
      checks++;
      if (layer_en !== 4'b0000) begin
         errors++;
         $display("FAIL clip_blank got %b want 0000", layer_en);
      end
      set_pix(2, 2);
      tick();
      tick();
      checks++;
      if ({o_red, o_green, o_blue, sel_valid, sel_layer} !== {10'h048, 10'h0D0, 10'h158, 3'b1_11}) begin
         errors++;
         $display("FAIL clip_out got %h %h %h sel %b %0d want 048 0d0 158 sel 1 3",
                  o_red, o_green, o_blue, sel_valid, sel_layer);
      end
   endtask

   task automatic test_last_write_wins();
      cfg_write(1, 200, 15, 20, 20, 1'b1, 1'b0);
      cfg_write(1, 300, 15, 20, 20, 1'b1, 1'b0);
      do_refresh();
      set_pix(305, 20);
      checks++;
      if (layer_en !== 4'b0010) begin
         errors++;
         $display("FAIL lww_second got %b want 0010", layer_en);
      end
      set_pix(205, 20);
      checks++;
      if (layer_en !== 4'b0000) begin
         errors++;
         $display("FAIL lww_first got %b want 0000", layer_en);
      end
   endtask

   task automatic test_reset_midframe();
      cfg_write(0, 10, 10, 20, 20, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      do_refresh();
      red = 10'h2A7; green = 10'h0F0; blue = 10'h301;
      set_pix(16, 16);
      checks++;
      if (layer_en !== 4'b0000) begin
         errors++;
         $display("FAIL midrst_layer_en got %b want 0000", layer_en);
      end
      tick();
      tick();
      checks++;
      if ({o_red, o_green, o_blue, sel_valid} !== {10'h2A7, 10'h0F0, 10'h301, 1'b0}) begin
         errors++;
         $display("FAIL midrst_out got %h %h %h sel %b want 2a7 0f0 301 sel 0",
                  o_red, o_green, o_blue, sel_valid);
      end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_transparency();
      test_circle();
      test_double_buffer();
      test_handshake_and_clip();
      test_last_write_wins();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

- Parametrised successor to the single-scene VGA overlay stage. It composites `N_LAYERS` positioned sprite layers over the camera background with fixed index priority, per-layer rectangular or circular masks and key transparency.
- Layer position, size and mode are double-buffered: they are written at any time through a valid/ready port and take effect only at frame start.
- Per frame, it reports which layers had opaque pixels overlapping another opaque layer. The collision and capture FSMs use this instead of ad-hoc enable ANDing.

## Interface

Parameters:
- `N_LAYERS`, default 4: number of sprite layers. Index 0 has the highest priority.
- `COLOR_W`, default 10: background/output channel width.
- `COORD_W`, default 13: signed counter and position width.
- `X_START`, default 216: first active h_count.
- `Y_START`, default 27: first active v_count.
- `H_ACT`, default 800: active pixels per line.
- `V_ACT`, default 600: active lines.

Ports:
- `i_clk`, in, 1: pixel clock.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_h_count`, in, `COORD_W` signed: horizontal counter. (0,0) marks frame start.
- `i_v_count`, in, `COORD_W` signed: vertical counter.
- `i_red`, `i_green`, `i_blue`, in, `COLOR_W` each: background pixel, aligned with the counters.
- `o_layer_en`, out, `N_LAYERS`: combinational window-hit flag per layer. Drives the image fetchers.
- `i_layer_q`, in, `32*N_LAYERS`: fetcher data for layer k at bits [32k+31:32k], laid out {R8, G8, B8, A8}. A8[7]=1 means opaque. Data is valid exactly 1 cycle after `o_layer_en`[k].
- `i_cfg_valid`, in, 1: configuration write request.
- `o_cfg_ready`, out, 1: configuration accepted when both valid and ready are high.
- `i_cfg_layer`, in, `$clog2(N_LAYERS)`: target layer.
- `i_cfg_x`, `i_cfg_y`, in, `COORD_W` signed each: top-left corner relative to the active origin.
- `i_cfg_w`, `i_cfg_h`, in, 10 each: size in pixels.
- `i_cfg_en`, in, 1: layer enable.
- `i_cfg_circle`, in, 1: circular mask mode.
- `o_red`, `o_green`, `o_blue`, out, `COLOR_W` each: composited pixel, registered.
- `o_sel_valid`, out, 1: a layer pixel won this output pixel.
- `o_sel_layer`, out, `$clog2(N_LAYERS)`: index of the winning layer.
- `o_overlap`, out, `N_LAYERS`: per-layer overlap flags for the previous frame.
- `o_frame_done`, out, 1: one-cycle pulse when `o_overlap` updates.

## Operation

- **Frame start (`refresh`):** `i_h_count==0 && i_v_count==0`.
- **Config write:** on `i_cfg_valid && o_cfg_ready`, store {x, y, w, h, en, circle} into the shadow entry for `i_cfg_layer` and set its pending bit.
  - A second write to the same layer before refresh overwrites the first; the last write wins.
  - `o_cfg_ready` = !refresh. A write presented in the refresh cycle stalls one cycle.
  - An `i_cfg_layer` value ≥ N_LAYERS is accepted and discarded.
- **Commit:** in the refresh cycle, every layer with its pending bit set copies shadow to active and clears pending. Other layers keep their active configuration.
- **Stage 0 (combinational):** compute ax = h − X_START and ay = v − Y_START.
  - `o_layer_en`[k] requires all of: en_k; 0 ≤ ax < H_ACT; 0 ≤ ay < V_ACT; x_k ≤ ax < x_k+w_k; y_k ≤ ay < y_k+h_k.
  - In circle mode, additionally dx² + dy² ≤ (w_k>>1)², where dx = ax − (x_k + (w_k>>1)) and dy = ay − (y_k + (w_k>>1)). Use 11-bit signed differences and 22-bit unsigned squares. Circle mode ignores h_k for the mask.
  - w=0 or h=0 never hits. Negative x/y are legal and clip partially off-screen sprites.
- **Stage 1 (registered hits, delayed background):**
  - A layer is visible if hit_k && q_k[7].
  - Winner = lowest visible index. Output = {q[31:24],2'b00} etc. for COLOR_W=10; generally the 8-bit value is left-justified and zero-padded.
  - If no layer is visible, output the background delayed 1 cycle.
- **Overlap accumulation:** if two or more layers are visible on a pixel, OR those layers' bits into the accumulator.
  - At refresh, copy the accumulator to `o_overlap` and clear it. A pixel being accumulated in that same cycle goes into the new frame.
- **Stage 2:** register RGB, `o_sel_valid` and `o_sel_layer`.

## Timing

- Latency from counters/background to `o_red/green/blue` is 2 cycles. `o_sel_*` carries the same latency.
- `o_layer_en` has 0-cycle combinational latency. Fetchers must return data with exactly 1-cycle latency.
- New configuration affects pixels from the refresh cycle onward.
  - Pixels in the 2-cycle pipeline from the previous frame use the previous frame's configuration.
- `o_overlap` updates in the refresh cycle. `o_frame_done` pulses in the next cycle.
- Reset values:
  - Active entries, shadow entries, pending bits and the overlap accumulator: 0. All layers are disabled.
  - Pipeline registers: 0.
  - Outputs: RGB 0, `o_sel_valid` 0, `o_sel_layer` 0, `o_overlap` 0, `o_frame_done` 0.
  - `o_cfg_ready` follows !refresh.
- Reset mid-frame discards pending writes and in-flight pixels. Output is background only (after 2 cycles) until new configuration is committed.

## Test plan

- **Reset state:** after reset, no config writes, background 0x155 → output 0x155 on all channels 2 cycles later; `o_layer_en`=0; `o_sel_valid`=0.
- **Priority:** layer 0 at (10,10,20,20) opaque red 0xFF0000, layer 1 at (15,15,20,20) opaque blue 0x0000FF. At pixel ax=16, ay=16 → output red 0x3FC, `o_sel_layer`=0. After the next refresh → `o_overlap`=4'b0011 and `o_frame_done` pulses.
- **Transparency:** same layers with layer 0 A8=0x00 → pixel (16,16) shows blue and `o_sel_layer`=1. At the next refresh `o_overlap`=0.
- **Circle:** layer 2, circle mode, (100,100,40,40) → hit at (120,100) (dx=0, dy=−20); miss at (100,100) (corner, 20²+20² > 400).
- **Double buffering and handshake:**
  - Write x=50 to layer 0 mid-frame → the old position stays in effect until refresh and the new one applies from the refresh cycle.
  - A write held in the refresh cycle sees `o_cfg_ready`=0 and is accepted on the following cycle.
  - Two writes to the same layer before refresh → only the second takes effect.
- **Clipping:** layer 3 at x=−5, w=10 → hits ax 0..4 only. No hit when ax < 0 or during blanking.
